// File: rtl/uart_msg_pkg.sv
// Shared types, message bytes and length for uart_msg_seq.
// Build option UART_MSG_COUNT_EN adds the 4-digit hex counter field to the message.
package uart_msg_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  localparam logic [7:0] CHAR_T  = 8'h54;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_2  = 8'h32;
  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam int MSG_LEN_CNT   = 11;
  localparam int MSG_LEN_NOCNT = 7;

`ifdef UART_MSG_COUNT_EN
  localparam int MSG_LEN = MSG_LEN_CNT;
`else
  localparam int MSG_LEN = MSG_LEN_NOCNT;
`endif

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

`ifdef UART_MSG_COUNT_EN
  function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [15:0] snap);
    logic [7:0] b;
    case (idx)
      4'd0, 4'd1: b = CHAR_T;
      4'd2:       b = CHAR_0;
      4'd3:       b = CHAR_2;
      4'd4:       b = CHAR_SP;
      4'd5:       b = nibble_to_ascii(snap[15:12]);
      4'd6:       b = nibble_to_ascii(snap[11:8]);
      4'd7:       b = nibble_to_ascii(snap[7:4]);
      4'd8:       b = nibble_to_ascii(snap[3:0]);
      4'd9:       b = CHAR_CR;
      4'd10:      b = CHAR_LF;
      default:    b = 8'h00;
    endcase
    return b;
  endfunction
`else
  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0, 4'd1: b = CHAR_T;
      4'd2:       b = CHAR_0;
      4'd3:       b = CHAR_2;
      4'd4:       b = CHAR_SP;
      4'd5:       b = CHAR_CR;
      4'd6:       b = CHAR_LF;
      default:    b = 8'h00;
    endcase
    return b;
  endfunction
`endif

endpackage

// File: rtl/uart_msg_timer.sv
// Auto-repeat interval timer: counts while run is high, pulses expire on the
// INTERVAL-th idle cycle. INTERVAL == 0 disables it.
module uart_msg_timer #(
  parameter int INTERVAL = 1000,
  parameter int TIMER_W  = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  generate
    if (INTERVAL == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset, run, clear};
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [TIMER_W-1:0] LAST = TIMER_W'(INTERVAL - 1);
      logic [TIMER_W-1:0] cnt_q, cnt_d;

      assign expire = run && (cnt_q == LAST);

      always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || !run || expire) cnt_d = '0;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

endmodule

// File: rtl/uart_msg_seq.sv
// Streams "TT02 hhhh\r\n" to a UART transmitter over valid/ready.
// Without UART_MSG_COUNT_EN the counter field is dropped and msg_count reads 0.
module uart_msg_seq #(
  parameter int INTERVAL = 1000,
  parameter int TIMER_W  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] msg_count
);
  import uart_msg_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] next_byte;
  logic       expire;
  logic       go;

  assign go = (state_q == IDLE) && (start || expire);

  uart_msg_timer #(.INTERVAL(INTERVAL), .TIMER_W(TIMER_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (state_q == IDLE),
    .clear  (go),
    .expire (expire)
  );

`ifdef UART_MSG_COUNT_EN
  logic [15:0] msg_count_q, msg_count_d;
  logic [15:0] snap_q, snap_d;

  // Digits are frozen at message start so a message never mixes two counts.
  always_comb begin
    snap_d      = go ? msg_count_q : snap_q;
    msg_count_d = (state_q == DONE) ? msg_count_q + 16'd1 : msg_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_count_q <= '0;
      snap_q      <= '0;
    end else begin
      msg_count_q <= msg_count_d;
      snap_q      <= snap_d;
    end
  end

  assign next_byte = msg_byte(idx_q + 4'd1, snap_q);
  assign msg_count = msg_count_q;
`else
  assign next_byte = msg_byte(idx_q + 4'd1);
  assign msg_count = 16'h0000;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        if (go) begin
          state_d    = SEND;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = CHAR_T;
        end
      end
      SEND: begin
        // Output registers are loaded one byte ahead so tx_data stays registered.
        if (tx_valid_q && tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d    = DONE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = next_byte;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_msg_seq.sv
// Directed bench for uart_msg_seq: manual starts on one instance (INTERVAL=0),
// auto-repeat on a second instance (INTERVAL=20).
module tb_uart_msg_seq;

`ifdef UART_MSG_COUNT_EN
  localparam int LEN = 11;
`else
  localparam int LEN = 7;
`endif

  logic        clk = 1'b0;
  logic        reset0, reset1;
  logic        start0, start1;
  logic        tx_ready0, tx_ready1;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1;
  logic        busy0, busy1;
  logic [15:0] msg_count0, msg_count1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_msg_seq #(.INTERVAL(0), .TIMER_W(20)) dut0 (
    .clk(clk), .reset(reset0), .start(start0), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .busy(busy0), .msg_count(msg_count0)
  );

  uart_msg_seq #(.INTERVAL(20), .TIMER_W(20)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .tx_data(tx_data1),
    .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1), .msg_count(msg_count1)
  );

  function automatic logic [7:0] exp_byte(input int idx, input int cnt);
    string pre;
    string hexd;
    pre  = "TT02 ";
    hexd = "0123456789ABCDEF";
    if (idx < 5) return pre[idx];
`ifdef UART_MSG_COUNT_EN
    if (idx < 9) return hexd[(cnt >> (4 * (8 - idx))) & 15];
`else
    if (cnt < 0) return hexd[0];
`endif
    if (idx == LEN - 2) return 8'h0D;
    return 8'h0A;
  endfunction

  function automatic logic [15:0] exp_count(input int cnt);
`ifdef UART_MSG_COUNT_EN
    return 16'(cnt);
`else
    return (cnt < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One message on dut0; optional stall, stray start pulses, or reset mid-message.
  task automatic run_msg(input int cnt, input int stall_idx, input bit poke_start, input int reset_idx);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      chk($sformatf("m%0d valid[%0d]", cnt, i), {15'd0, tx_valid0}, 16'd1);
      chk($sformatf("m%0d data[%0d]", cnt, i), {8'd0, tx_data0}, {8'd0, exp_byte(i, cnt)});
      chk($sformatf("m%0d busy[%0d]", cnt, i), {15'd0, busy0}, 16'd1);
      if (i == reset_idx) begin
        #2 reset0 = 1'b0;
        #1;
        chk("async valid", {15'd0, tx_valid0}, 16'd0);
        chk("async busy", {15'd0, busy0}, 16'd0);
        chk("async count", msg_count0, 16'd0);
        @(negedge clk);
        reset0 = 1'b1;
        $display("message %0d aborted by reset at byte %0d", cnt, i);
        return;
      end
      if (i == stall_idx) begin
        tx_ready0 = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall valid", {15'd0, tx_valid0}, 16'd1);
          chk("stall data", {8'd0, tx_data0}, {8'd0, exp_byte(i, cnt)});
        end
        tx_ready0 = 1'b1;
      end
      start0 = poke_start && (i == 2 || i == 8);
      @(negedge clk);
      start0 = 1'b0;
    end
    chk("done valid", {15'd0, tx_valid0}, 16'd0);
    chk("done busy", {15'd0, busy0}, 16'd1);
    @(negedge clk);
    chk("idle busy", {15'd0, busy0}, 16'd0);
    chk("msg_count", msg_count0, exp_count(cnt + 1));
    $display("message %0d sent, msg_count=%h", cnt, msg_count0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset0 = 1'b0; reset1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    tx_ready0 = 1'b1; tx_ready1 = 1'b1;

    @(negedge clk);
    chk("reset valid", {15'd0, tx_valid0}, 16'd0);
    chk("reset data", {8'd0, tx_data0}, 16'd0);
    chk("reset busy", {15'd0, busy0}, 16'd0);
    chk("reset count", msg_count0, 16'd0);
    reset0 = 1'b1;
    @(negedge clk);
    chk("no auto start", {15'd0, tx_valid0}, 16'd0);

    run_msg(0, -1, 1'b0, -1);
    run_msg(1, -1, 1'b0, -1);
    run_msg(2, 3, 1'b0, -1);
    run_msg(3, -1, 1'b1, -1);
    @(negedge clk);
    chk("no queued start", {15'd0, tx_valid0}, 16'd0);
    chk("no queued busy", {15'd0, busy0}, 16'd0);
    run_msg(4, -1, 1'b0, 6);
    run_msg(0, -1, 1'b0, -1);

    // Auto-repeat: 20 idle cycles, then a message, three times.
    reset1 = 1'b1;
    repeat (19) @(negedge clk);
    chk("auto early", {15'd0, tx_valid1}, 16'd0);
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < LEN; i++) begin
        chk($sformatf("a%0d valid[%0d]", m, i), {15'd0, tx_valid1}, 16'd1);
        chk($sformatf("a%0d data[%0d]", m, i), {8'd0, tx_data1}, {8'd0, exp_byte(i, m)});
        @(negedge clk);
      end
      chk("auto done valid", {15'd0, tx_valid1}, 16'd0);
      repeat (20) @(negedge clk);
      chk("auto idle valid", {15'd0, tx_valid1}, 16'd0);
      chk("auto idle busy", {15'd0, busy1}, 16'd0);
      chk("auto count", msg_count1, exp_count(m + 1));
      $display("auto message %0d sent, msg_count=%h", m, msg_count1);
      if (m < 2) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
